tribus_arbiter: RTL and testbench
=================================

Name: tribus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared multi-driver tri net bus. Up to N_REQ requesters each own a tri-state driver onto one W-bit bus.
- The block grants exactly one driver at a time and enforces a one-cycle all-drivers-off turnaround between owners, so the bus is never contended.
- It also caps bus tenure, forcibly revoking a grant after MAX_HOLD cycles.
- Sits between requester logic and the tri-net bus fabric; drv_en outputs gate the per-requester bufif-style drivers.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure (>=1).
- IDX_W, $clog2(N_REQ), width of owner index (derived, not overridden).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester; level, held while the requester wants the bus.
- gnt  output  N_REQ  one-hot grant; at most one bit high.
- drv_en  output  N_REQ  tri-driver enable; equals gnt, registered, never high during TURN.
- owner  output  IDX_W  index of current grantee; valid only when bus_busy=1.
- bus_busy  output  1  high while in GRANT.
- hold_cnt  output  $clog2(MAX_HOLD+1)  cycles elapsed in current tenure, 1..MAX_HOLD in GRANT, 0 otherwise.
- timeout  output  1  one-cycle pulse on a forced revoke.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, gnt=0, drv_en=0, owner=0, bus_busy=0, hold_cnt=0, timeout=0, last_owner=N_REQ-1, so requester 0 has top priority first. Reset overrides everything, including mid-tenure: drivers are released the next edge.
- States: IDLE, GRANT, TURN. All outputs are registered.
- Arbitration (IDLE or TURN): search req starting at (last_owner+1) mod N_REQ, wrapping.
  - Winner w found: next state GRANT, gnt[w]=1, drv_en[w]=1, owner=w, last_owner=w, hold_cnt=1.
  - No request: next state IDLE.
- Latency: req rising in IDLE yields gnt at the next edge, i.e. 1 cycle.
- GRANT exit conditions, evaluated each cycle on sampled inputs:
  - req[owner]=0: voluntary release.
  - hold_cnt==MAX_HOLD: forced revoke; timeout=1 for the next cycle only.
  - Either exit: next state TURN, gnt=0, drv_en=0, hold_cnt=0.
  - Otherwise: stay in GRANT and hold_cnt increments.
- Tenure length: a grantee holding req continuously is granted exactly MAX_HOLD cycles. A release with req low at cycle k gives k-1 granted cycles after first grant (gnt drops 1 cycle after req drops).
- TURN always lasts exactly 1 cycle with all drv_en low, then arbitrates as above.
  - The TURN->GRANT path takes 2 cycles from the end of one grant to the next; there is no back-to-back owner change.
  - A revoked requester still requesting is re-granted only after all other pending requesters, because of rotation. If it is the only requester, it is re-granted after the TURN cycle.
- req of non-owners during GRANT is ignored until the next arbitration point. Requests are not latched: a pulse that drops before arbitration is lost.
- Invariants: $onehot0(gnt); drv_en==gnt; gnt==0 in IDLE and TURN.

Decomposition:
- Shared package tribus_pkg: state enum {IDLE, GRANT, TURN}, default N_REQ/MAX_HOLD constants.
- One natural sub-module: rr_pick, a combinational round-robin priority picker with inputs req and last_owner, outputs found and winner index. It is reused by future bus controllers.
- The FSM, counter and output registers stay in tribus_arbiter.

Test Plan:
- Reset mid-grant: req=4'b0001 granted, assert rst for 1 cycle -> next edge gnt=0, drv_en=0, hold_cnt=0, state IDLE; with req still 0001, gnt=0001 1 cycle after rst drops.
- Single requester: req=4'b0100 from IDLE -> gnt=0100 after 1 cycle, owner=2; drop req -> gnt=0 next edge, 1 TURN cycle, then IDLE.
- Round robin: req=4'b1111 held, MAX_HOLD=4 -> grant order 0,1,2,3,0, each exactly 4 cycles with timeout pulse, one all-zero TURN cycle between each.
- Wrap-around: last_owner=3, req=4'b1001 -> requester 0 wins; then last_owner=0 with req=4'b1001 -> requester 3 wins.
- Sole hog: req=4'b0010 held with MAX_HOLD=16 -> gnt high for 16 cycles, timeout=1 once, 1 TURN cycle, re-granted to 1; repeats.
- Invariant sweep: 10k cycles of random req -> gnt never has more than one bit set, drv_en==gnt, and every owner change has at least one drv_en==0 cycle between.

Source files
------------

// File: rtl/tribus_pkg.sv
// Shared types and defaults for the tri-net bus arbiter family.
package tribus_pkg;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_MAX_HOLD = 16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Single-step modulo wrap, valid for idx < 2*n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner, wrapping.
module rr_pick
    import tribus_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic             found_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester after last_owner wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        for (int unsigned k = N_REQ; k != 0; k--) begin
            cand = IDX_W'(rr_wrap(32'(last_owner_i) + k, N_REQ));
            if (req_i[cand]) begin
                found_o  = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin grant sequencer for a shared tri-net bus with turnaround and tenure cap.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter  int unsigned N_REQ    = DEF_N_REQ,
    parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
    localparam int unsigned IDX_W    = $clog2(N_REQ),
    localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  drv_en,
    output logic [IDX_W-1:0]  owner,
    output logic              bus_busy,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              timeout
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  drv_en_q;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_winner;
    logic              at_max;
    logic              owner_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (req),
        .last_owner_i (last_q),
        .found_o      (pick_found),
        .winner_o     (pick_winner)
    );

    assign at_max    = (hold_q == HOLD_W'(MAX_HOLD));
    assign owner_req = req[owner_q];

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = '0;
        busy_d    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << pick_winner;
                    owner_d = pick_winner;
                    last_d  = pick_winner;
                    hold_d  = HOLD_W'(1);
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!owner_req || at_max) begin
                    // A release coinciding with the cap is voluntary, not a revoke.
                    state_d   = TURN;
                    timeout_d = owner_req && at_max;
                end else begin
                    state_d = GRANT;
                    gnt_d   = gnt_q;
                    busy_d  = 1'b1;
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            drv_en_q  <= '0;
            owner_q   <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            drv_en_q  <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt      = gnt_q;
    assign drv_en   = drv_en_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign hold_cnt = hold_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter: expected tenures queued by stimulus, checked by a monitor.
module tb_tribus_arbiter;

    localparam int NR = 4;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [NR-1:0] drv_en;
    logic [1:0]    owner;
    logic          bus_busy;
    logic [2:0]    hold_cnt;
    logic          timeout;

    int total = 0;
    int bad   = 0;
    bit mon_en    = 1'b0;
    bit rand_mode = 1'b0;

    typedef struct {
        int owner;
        int len;
        int tmo;
        int gap;
    } tenure_t;

    tenure_t exp_q[$];

    tribus_arbiter #(
        .N_REQ    (NR),
        .MAX_HOLD (MH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .drv_en   (drv_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .hold_cnt (hold_cnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int gidx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ten(input int o, input int l, input int t, input int g);
        tenure_t e;
        e.owner = o;
        e.len   = l;
        e.tmo   = t;
        e.gap   = g;
        exp_q.push_back(e);
    endtask

    // Monitor state, sampled on the falling edge.
    logic [NR-1:0] prev_gnt;
    logic [NR-1:0] prev_req;
    int            len;
    int            gap;
    int            cur_own;
    bit            stay;
    int            exp_tmo;
    tenure_t       e;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_gnt = '0;
            prev_req = '0;
            len      = 0;
            gap      = 0;
            cur_own  = 0;
        end else begin
            chk("onehot0", int'($onehot0(gnt)), 1);
            chk("drv_en_eq_gnt", int'(drv_en), int'(gnt));
            chk("bus_busy", int'(bus_busy), int'(gnt != '0));
            // Continuation and revoke predicted from the previous sample.
            exp_tmo = 0;
            if (prev_gnt != '0) begin
                stay = prev_req[cur_own] && (len < MH);
                chk("gnt_next", int'(gnt), stay ? int'(prev_gnt) : 0);
                exp_tmo = (prev_req[cur_own] && len == MH) ? 1 : 0;
            end
            chk("timeout", int'(timeout), exp_tmo);
            if (gnt != '0) begin
                if (prev_gnt == '0) begin
                    cur_own = gidx(gnt);
                    len     = 1;
                    if (!rand_mode) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_tenure", cur_own, -1);
                        end else begin
                            chk("tenure_owner", cur_own, exp_q[0].owner);
                            if (exp_q[0].gap >= 0) chk("turn_gap", gap, exp_q[0].gap);
                        end
                    end
                end else begin
                    len++;
                end
                chk("owner", int'(owner), cur_own);
                chk("hold_cnt", int'(hold_cnt), len);
            end else begin
                if (prev_gnt != '0) begin
                    if (!rand_mode && exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tenure_len", len, e.len);
                        chk("tenure_timeout", int'(timeout), e.tmo);
                    end
                    gap = 1;
                end else begin
                    gap++;
                end
                chk("hold_cnt_idle", int'(hold_cnt), 0);
            end
            prev_gnt = gnt;
            prev_req = req;
        end
    end

    initial begin
        // Reset state and priority after reset.
        tick(3);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_drv_en", int'(drv_en), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_hold", int'(hold_cnt), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        req = 4'b0011;
        tick(1);
        chk("first_gnt", int'(gnt), 1);
        chk("first_drv_en", int'(drv_en), 1);
        chk("first_owner", int'(owner), 0);
        chk("first_hold", int'(hold_cnt), 1);
        chk("first_busy", int'(bus_busy), 1);
        req = 4'b0001;
        tick(1);
        chk("hold_two", int'(hold_cnt), 2);
        // Reset mid-grant.
        rst = 1'b1;
        tick(1);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_drv_en", int'(drv_en), 0);
        chk("midrst_hold", int'(hold_cnt), 0);
        chk("midrst_busy", int'(bus_busy), 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_gnt", int'(gnt), 1);
        req = 4'b0000;
        tick(1);
        chk("release_gnt", int'(gnt), 0);
        tick(3);
        mon_en = 1'b1;

        // Single requester with voluntary release.
        exp_ten(2, 3, 0, -1);
        req = 4'b0100; tick(3);
        req = 4'b0000; tick(4);

        // Wrap-around: 3 then 0 wins over 3, then 3 wins over 0.
        exp_ten(3, 2, 0, -1);
        exp_ten(0, MH, 1, 1);
        exp_ten(3, MH, 1, 1);
        req = 4'b1000; tick(2);
        req = 4'b0000; tick(1);
        req = 4'b1001; tick(10);
        req = 4'b0000; tick(4);

        // Full round robin with forced revokes.
        exp_ten(0, MH, 1, -1);
        exp_ten(1, MH, 1, 1);
        exp_ten(2, MH, 1, 1);
        exp_ten(3, MH, 1, 1);
        exp_ten(0, MH, 1, 1);
        req = 4'b1111; tick(25);
        req = 4'b0000; tick(4);

        // Sole hog re-granted after one turnaround.
        exp_ten(1, MH, 1, -1);
        exp_ten(1, MH, 1, 1);
        req = 4'b0010; tick(10);
        req = 4'b0000; tick(4);

        // Non-owner request ignored until release, then served.
        exp_ten(0, 2, 0, -1);
        exp_ten(2, 2, 0, 1);
        req = 4'b0001; tick(1);
        req = 4'b0101; tick(1);
        req = 4'b0100; tick(3);
        req = 4'b0000; tick(4);

        // Random sweep against the invariant model.
        rand_mode = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            tick(1);
        end
        req = 4'b0000;
        tick(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
